// File: rtl/stream_acq_if.sv
// rtl/stream_acq_if.sv - Pin and handshake bundle between stream_acq_ctrl and its surroundings
interface stream_acq_if;
    logic       init;
    logic       MISO;
    logic       video_data_ready;
    logic       audio_data_ready;
    logic       MOSI;
    logic       chip_select;
    logic       SPI_clk_en;
    logic       audio_clk_en;
    logic       write_video;
    logic       write_audio;
    logic [7:0] audio_byte;
    logic       start_req;
    logic       read_bank1;
    logic       read_bank2;
    logic       write_bank1;
    logic       write_bank2;

    modport master (
        input  init, MISO, video_data_ready, audio_data_ready,
        output MOSI, chip_select, SPI_clk_en, audio_clk_en, write_video, write_audio,
               audio_byte, start_req, read_bank1, read_bank2, write_bank1, write_bank2
    );

    modport slave (
        output init, MISO, video_data_ready, audio_data_ready,
        input  MOSI, chip_select, SPI_clk_en, audio_clk_en, write_video, write_audio,
               audio_byte, start_req, read_bank1, read_bank2, write_bank1, write_bank2
    );
endinterface

// File: rtl/stream_acq_ctrl.sv
// rtl/stream_acq_ctrl.sv - SPI acquisition FSM, strobe generators and bank ping-pong; STREAM_AUDIO_EN adds the audio block
module stream_acq_ctrl #(
    parameter int         SPI_DIV     = 40,
    parameter int         AUDIO_DIV   = 907,
    parameter logic [7:0] CMD_BYTE    = 8'h52,
    parameter logic [7:0] HEADER_BYTE = 8'hFF,
    parameter int         VIDEO_BITS  = 76800,
    parameter int         AUDIO_BYTES = 32
) (
    input  logic         CLK_40,
    input  logic         reset,
    stream_acq_if.master bus
);
    localparam int CW = $clog2(VIDEO_BITS + 1);
    localparam int SW = $clog2(SPI_DIV + 1);
    localparam int AW = $clog2(AUDIO_DIV + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_HUNT, S_VIDEO, S_AUDIO, S_WAIT} state_t;
    typedef enum logic [1:0] {M_IDLE, M_W1R2, M_W2R1} mode_t;

    state_t        state, state_nx;
    mode_t         mode, mode_nx;
    logic [SW-1:0] spi_cnt;
    logic [AW-1:0] aud_cnt;
    logic          spi_en, aud_tick;
    logic [6:0]    shift_reg;
    logic [7:0]    sample;
    logic [CW-1:0] bit_cnt, byte_cnt;
    logic          mosi_q;
    logic          header_hit, last_video, last_byte, byte_done, start_req, audio_ok;

    assign spi_en   = (spi_cnt == SW'(SPI_DIV - 1));
    assign aud_tick = (aud_cnt == AW'(AUDIO_DIV - 1));

    // Free-running SPI bit-rate divider
    always_ff @(posedge CLK_40) begin
        if (reset || spi_en) spi_cnt <= '0;
        else                 spi_cnt <= spi_cnt + SW'(1);
    end

    // Free-running audio sample-rate divider
    always_ff @(posedge CLK_40) begin
        if (reset || aud_tick) aud_cnt <= '0;
        else                   aud_cnt <= aud_cnt + AW'(1);
    end

    // The byte as it will look once the current MISO bit is shifted in
    assign sample     = {shift_reg, bus.MISO};
    // Only samples taken inside HUNT count toward a header (bit_cnt saturates at 7 there)
    assign header_hit = (bit_cnt >= CW'(7)) && (sample == HEADER_BYTE);
    assign last_video = (bit_cnt == CW'(VIDEO_BITS - 1));
    assign byte_done  = (bit_cnt == CW'(7));
    assign last_byte  = (byte_cnt == CW'(AUDIO_BYTES - 1));
    assign start_req  = (state == S_VIDEO) && spi_en && last_video;

`ifdef STREAM_AUDIO_EN
    assign audio_ok = bus.audio_data_ready;
`else
    logic audio_path_unused;
    assign audio_ok          = 1'b1;
    assign audio_path_unused = bus.audio_data_ready ^ aud_tick;
`endif

    // Data FSM state register
    always_ff @(posedge CLK_40) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Data FSM next-state; bit-level moves only happen on SPI strobes
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.init) state_nx = S_CMD;
            S_CMD:   if (spi_en && byte_done) state_nx = S_HUNT;
            S_HUNT:  if (spi_en && header_hit) state_nx = S_VIDEO;
            S_VIDEO: if (spi_en && last_video) begin
`ifdef STREAM_AUDIO_EN
                state_nx = S_AUDIO;
`else
                state_nx = S_WAIT;
`endif
            end
            S_AUDIO: if (spi_en && byte_done && last_byte) state_nx = S_WAIT;
            S_WAIT:  if (bus.video_data_ready && audio_ok) state_nx = S_HUNT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Shift register, bit/byte counters and MOSI; counters restart on every state change
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            mosi_q    <= 1'b0;
        end else begin
            if (spi_en) begin
                shift_reg <= sample[6:0];
                if (state == S_CMD)       mosi_q <= CMD_BYTE[~bit_cnt[2:0]];
                else if (state != S_IDLE) mosi_q <= 1'b1;
            end
            if (state_nx != state) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (spi_en) begin
                case (state)
                    S_CMD, S_VIDEO: bit_cnt <= bit_cnt + CW'(1);
                    S_HUNT:  if (!byte_done) bit_cnt <= bit_cnt + CW'(1);
                    S_AUDIO: begin
                        if (byte_done) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt + CW'(1);
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef STREAM_AUDIO_EN
    logic [7:0] aud_byte_q;
    logic       wr_aud_q;

    // Capture each completed audio byte; write_audio and audio_byte appear together
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            aud_byte_q <= '0;
            wr_aud_q   <= 1'b0;
        end else begin
            wr_aud_q <= 1'b0;
            if (state == S_AUDIO && spi_en && byte_done) begin
                aud_byte_q <= sample;
                wr_aud_q   <= 1'b1;
            end
        end
    end

    assign bus.audio_clk_en = aud_tick;
    assign bus.write_audio  = wr_aud_q;
    assign bus.audio_byte   = aud_byte_q;
`else
    assign bus.audio_clk_en = 1'b0;
    assign bus.write_audio  = 1'b0;
    assign bus.audio_byte   = 8'h00;
`endif

    // Mode FSM state register
    always_ff @(posedge CLK_40) begin
        if (reset) mode <= M_IDLE;
        else       mode <= mode_nx;
    end

    // Mode FSM: init arms W1R2, each end of frame swaps the bank roles
    always_comb begin
        mode_nx = mode;
        case (mode)
            M_IDLE:  if (bus.init) mode_nx = M_W1R2;
            M_W1R2:  if (start_req) mode_nx = M_W2R1;
            M_W2R1:  if (start_req) mode_nx = M_W1R2;
            default: mode_nx = M_IDLE;
        endcase
    end

    assign bus.MOSI        = mosi_q;
    assign bus.chip_select = (state == S_IDLE);
    assign bus.SPI_clk_en  = spi_en;
    assign bus.write_video = (state == S_VIDEO) && spi_en;
    assign bus.start_req   = start_req;
    assign bus.write_bank1 = (mode == M_W1R2);
    assign bus.read_bank2  = (mode == M_W1R2);
    assign bus.write_bank2 = (mode == M_W2R1);
    assign bus.read_bank1  = (mode == M_W2R1);
endmodule

// File: tb/tb_stream_acq_ctrl.sv
// tb/tb_stream_acq_ctrl.sv - Scoreboard bench for stream_acq_ctrl
module tb_stream_acq_ctrl;
    localparam int K_START = 0;
    localparam int K_BANKS = 1;
    localparam int K_AUDIO = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic CLK_40;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    stream_acq_if bus();

    stream_acq_ctrl #(
        .VIDEO_BITS (16),
        .AUDIO_BYTES(2)
    ) dut (
        .CLK_40(CLK_40),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK_40 = 1'b0;
    always #5 CLK_40 = ~CLK_40;

    function automatic logic [3:0] banks();
        return {bus.write_bank1, bus.write_bank2, bus.read_bank1, bus.read_bank2};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [31:0] act, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: unexpected event got 0x%0h expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: event kind %0d expected kind %0d", name, kind, e.kind);
            end else begin
                check(name, act, e.val);
            end
        end
    endtask

    // Monitor: frame length, bank swap and audio bytes are popped against the scoreboard
    initial begin
        int  vid_cnt = 0;
        bit  bank_due = 0;
        forever begin
            @(negedge CLK_40);
            if (reset) begin
                vid_cnt  = 0;
                bank_due = 0;
            end else begin
                if (bank_due) begin
                    pop_check(K_BANKS, 32'(banks()), "banks_after_swap");
                    bank_due = 0;
                end
                if (bus.write_video) vid_cnt++;
                if (bus.start_req) begin
                    check("start_with_video", 32'(bus.write_video), 32'd1);
                    pop_check(K_START, 32'(vid_cnt), "frame_bits");
                    vid_cnt  = 0;
                    bank_due = 1;
                end
                if (bus.write_audio) pop_check(K_AUDIO, 32'(bus.audio_byte), "audio_byte");
            end
        end
    end

    // Present one MISO bit and let exactly one SPI strobe consume it
    task automatic send_bit(input logic b, output logic wv, output logic sr);
        int n = 0;
        bus.MISO = b;
        wv = 1'b0;
        sr = 1'b0;
        @(negedge CLK_40);
        while (!bus.SPI_clk_en && n < 100) begin
            @(negedge CLK_40);
            n++;
        end
        if (!bus.SPI_clk_en) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_timeout: got no SPI_clk_en expected one within 100 cycles");
        end
        wv = bus.write_video;
        sr = bus.start_req;
        @(posedge CLK_40);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic wv, sr;
        for (int i = 7; i >= 0; i--) send_bit(v[i], wv, sr);
    endtask

    task automatic do_init();
        logic       wv, sr;
        logic [7:0] cmd = 8'h52;
        bus.MISO = 1'b1;
        bus.init = 1'b1;
        @(posedge CLK_40);
        #1;
        bus.init = 1'b0;
        check("cs_after_init", 32'(bus.chip_select), 32'd0);
        check("banks_after_init", 32'(banks()), 32'h9);
        for (int k = 0; k < 8; k++) begin
            send_bit(1'b1, wv, sr);
            check($sformatf("mosi_cmd_bit%0d", k), 32'(bus.MOSI), 32'(cmd[7-k]));
        end
    endtask

    task automatic frame(input logic [3:0] exp_banks);
        logic wv, sr;
        int   quiet = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, wv, sr);
            quiet += int'(wv);
            if (i == 0) check("mosi_idle_high", 32'(bus.MOSI), 32'd1);
        end
        check("hunt_no_video", 32'(quiet), 32'd0);
        push(K_START, 32'd16);
        push(K_BANKS, 32'(exp_banks));
        for (int i = 0; i < 16; i++) begin
            send_bit(1'($urandom_range(0, 1)), wv, sr);
            if (i == 0)  check("first_video_strobe", 32'(wv), 32'd1);
            if (i == 15) check("start_req_16th", 32'(sr), 32'd1);
        end
    endtask

    task automatic hold_wait(input int cycles, input string name);
        int wv_n = 0;
        int cs_n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK_40);
            wv_n += int'(bus.write_video);
            cs_n += int'(bus.chip_select);
        end
        check({name, "_video"}, 32'(wv_n), 32'd0);
        check({name, "_cs"}, 32'(cs_n), 32'd0);
    endtask

    initial begin
        logic wv, sr;
        int   last_spi = 0, last_aud = 0, n_spi = 0, n_aud = 0, idle_bad = 0, wv_n = 0, cs_hi = 0;

        reset = 1'b1;
        bus.init = 1'b0;
        bus.MISO = 1'b0;
        bus.video_data_ready = 1'b0;
        bus.audio_data_ready = 1'b0;
        repeat (3) @(posedge CLK_40);
        #1;
        reset = 1'b0;

        check("rst_cs", 32'(bus.chip_select), 32'd1);
        check("rst_mosi", 32'(bus.MOSI), 32'd0);
        check("rst_banks", 32'(banks()), 32'd0);
        check("rst_pulses", 32'({bus.SPI_clk_en, bus.audio_clk_en, bus.write_video,
                                 bus.write_audio, bus.start_req}), 32'd0);
        check("rst_audio_byte", 32'(bus.audio_byte), 32'd0);

        for (int n = 1; n <= 1900; n++) begin
            @(negedge CLK_40);
            if (bus.SPI_clk_en) begin
                check("spi_period", 32'(n - last_spi), 32'd40);
                last_spi = n;
                n_spi++;
            end
            if (bus.audio_clk_en) begin
                check("audio_period", 32'(n - last_aud), 32'd907);
                last_aud = n;
                n_aud++;
            end
            if (!bus.chip_select || banks() != 4'h0 || bus.write_video) idle_bad++;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);
        check("spi_strobe_count", 32'(n_spi), 32'd47);
`ifdef STREAM_AUDIO_EN
        check("audio_strobe_count", 32'(n_aud), 32'd2);
`else
        check("audio_strobe_count", 32'(n_aud), 32'd0);
`endif
        @(posedge CLK_40);
        #1;

        do_init();
        frame(4'h6);
`ifdef STREAM_AUDIO_EN
        push(K_AUDIO, 32'hA5);
        push(K_AUDIO, 32'h3C);
        send_byte(8'hA5);
        send_byte(8'h3C);
`endif

        bus.MISO = 1'b1;
        bus.audio_data_ready = 1'b1;
        hold_wait(400, "wait_no_video_ready");
`ifdef STREAM_AUDIO_EN
        bus.video_data_ready = 1'b1;
        bus.audio_data_ready = 1'b0;
        hold_wait(400, "wait_no_audio_ready");
        bus.audio_data_ready = 1'b1;
`else
        bus.video_data_ready = 1'b1;
        bus.audio_data_ready = 1'b0;
`endif
        @(posedge CLK_40);
        #1;
        frame(4'h9);
`ifdef STREAM_AUDIO_EN
        push(K_AUDIO, 32'h0F);
        push(K_AUDIO, 32'hF0);
        send_byte(8'h0F);
        send_byte(8'hF0);
`endif

        for (int i = 0; i < 8; i++) send_bit(1'b1, wv, sr);
        for (int i = 0; i < 5; i++) send_bit(1'b0, wv, sr);
        check("mid_video_pulse", 32'(wv), 32'd1);
        reset = 1'b1;
        @(posedge CLK_40);
        #1;
        check("reset_cs", 32'(bus.chip_select), 32'd1);
        check("reset_banks", 32'(banks()), 32'd0);
        check("reset_mosi", 32'(bus.MOSI), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK_40);
            wv_n += int'(bus.write_video);
            cs_hi += int'(bus.chip_select);
        end
        check("post_reset_video", 32'(wv_n), 32'd0);
        check("post_reset_cs", 32'(cs_hi), 32'd300);
        @(posedge CLK_40);
        #1;

        do_init();
        frame(4'h6);
        repeat (5) @(negedge CLK_40);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
